// File: rtl/muldiv_if.sv
// Bundle of request, MTHI/MTLO write, status and HI/LO result signals for muldiv_unit.
// With MULDIV_DIVZERO_FLAG_EN defined the bundle also carries div_by_zero.
interface muldiv_if #(parameter int DATA_WIDTH = 32) ();
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  wr_hi;
  logic                  wr_lo;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [1:0]            dbg_state;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic                  div_by_zero;

  modport master (
    output start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo, dbg_state, div_by_zero
  );
  modport slave (
    input  start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo, dbg_state, div_by_zero
  );
`else
  modport master (
    output start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo, dbg_state
  );
  modport slave (
    input  start, op, op_a, op_b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo, dbg_state
  );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional MULDIV_DIVZERO_FLAG_EN adds a sticky div_by_zero status output.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  // Handshake: start is sampled only in IDLE; busy covers RUN and FIX; done is a
  // one-cycle pulse in DONE (busy low) marking HI/LO freshly written. A start in
  // DONE is ignored and must be held or re-issued once the unit is back in IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          is_div, sign_a, neg_res, b_zero;
  logic [W-1:0]  m_reg, a_raw, work_hi, work_lo;
  logic [W-1:0]  hi_q, lo_q;

  logic          sgn_in, neg_a_in, neg_b_in;
  logic [W-1:0]  mag_a_in, mag_b_in;
  logic [W:0]    mul_sum, rem_sh;
  logic          rem_ge;
  logic [W-1:0]  rem_sub;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]  quo_fix, rem_fix, res_hi, res_lo;

  assign sgn_in   = ~bus.op[0];
  assign neg_a_in = sgn_in & bus.op_a[W-1];
  assign neg_b_in = sgn_in & bus.op_b[W-1];
  assign mag_a_in = neg_a_in ? -bus.op_a : bus.op_a;
  assign mag_b_in = neg_b_in ? -bus.op_b : bus.op_b;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // One iteration step: multiply adds into the upper half and shifts right;
  // divide shifts the dividend into the partial remainder and restores on borrow.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, m_reg} : '0);
    rem_sh  = {work_hi, work_lo[W-1]};
    rem_ge  = (rem_sh >= {1'b0, m_reg});
    rem_sub = W'(rem_sh - {1'b0, m_reg});
  end

  always_comb begin
    prod     = {work_hi, work_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -work_lo : work_lo;
    rem_fix  = sign_a ? -work_hi : work_hi;
    res_hi   = prod_fix[2*W-1:W];
    res_lo   = prod_fix[W-1:0];
    if (is_div) begin
      // Divide by zero reports the raw dividend in HI regardless of signedness.
      res_hi = b_zero ? a_raw : rem_fix;
      res_lo = b_zero ? '1 : quo_fix;
    end
  end

  // RUN lasts W+1 cycles: W iteration cycles followed by one settle cycle, which
  // gives the fixed E0-to-done latency of W+2 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      sign_a  <= 1'b0;
      neg_res <= 1'b0;
      b_zero  <= 1'b0;
      m_reg   <= '0;
      a_raw   <= '0;
      work_hi <= '0;
      work_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            is_div  <= bus.op[1];
            sign_a  <= neg_a_in;
            neg_res <= neg_a_in ^ neg_b_in;
            b_zero  <= (bus.op_b == '0);
            a_raw   <= bus.op_a;
            m_reg   <= bus.op[1] ? mag_b_in : mag_a_in;
            work_hi <= '0;
            work_lo <= bus.op[1] ? mag_a_in : mag_b_in;
          end else begin
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        RUN: begin
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
              work_hi <= rem_ge ? rem_sub : rem_sh[W-1:0];
              work_lo <= {work_lo[W-2:0], rem_ge};
            end else begin
              work_hi <= mul_sum[W:1];
              work_lo <= {mul_sum[0], work_lo[W-1:1]};
            end
          end
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  logic div0_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div0_flag <= 1'b0;
    else if (state == FIX)
      div0_flag <= is_div & b_zero;
    else if (state == IDLE && !bus.start && (bus.wr_hi || bus.wr_lo))
      div0_flag <= 1'b0;
  end

  assign bus.div_by_zero = div0_flag;
`endif

  assign bus.busy      = (state == RUN) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];
  logic exp_flag;

  muldiv_if #(.DATA_WIDTH(W)) bus ();
  muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {hi, lo} from plain integer arithmetic; SV division truncates toward zero
  // and the remainder follows the dividend, matching the required semantics.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 0;
    r = 0;
    case (o)
      2'b00:   res = 64'(sa * sb);
      2'b01:   res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (o == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issues one operation from IDLE (#1 after an edge), scrambles operands after
  // acceptance, waits for done and checks latency, busy, result and flag.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat;
    bit seen;
    exp_q.push_back(model(o, a, b));
    bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_op op=%0d cycle=%0d got=%b want=1", o, lat, bus.busy);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout op=%0d a=%h b=%h waited=%0d", o, a, b, lat);
      void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL latency op=%0d got=%0d want=%0d", o, lat, LAT);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done op=%0d got=%b want=0", o, bus.busy);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
               o, a, b, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    exp_flag = o[1] && (b == 32'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
    checks++;
    if (bus.div_by_zero !== exp_flag) begin
      errors++;
      $display("FAIL div_by_zero_flag op=%0d b=%h got=%b want=%b", o, b, bus.div_by_zero, exp_flag);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b state=%0d want done=0 state=0", bus.done, bus.dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.op_a = '0; bus.op_b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    exp_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 ||
        bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b hi=%h lo=%h state=%0d want all 0",
               bus.busy, bus.done, bus.hi, bus.lo, bus.dbg_state);
    end
`ifdef MULDIV_DIVZERO_FLAG_EN
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flag got=%b want=0", bus.div_by_zero);
    end
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd7, 32'd2);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_divzero();
    run_op(2'b11, 32'd5, 32'd0);
    run_op(2'b01, 32'd2, 32'd3);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0);
    run_op(2'b00, 32'd0, 32'd0);
  endtask

  task automatic test_mthi_mtlo();
    bus.wr_hi = 1'b1; bus.wr_data = 32'h1111_2222;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h3333_4444;
    @(posedge clk); #1;
    bus.wr_lo = 1'b0;
    checks++;
    if (bus.hi !== 32'h1111_2222 || bus.lo !== 32'h3333_4444) begin
      errors++;
      $display("FAIL mthi_mtlo got hi=%h lo=%h want hi=11112222 lo=33334444", bus.hi, bus.lo);
    end
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    exp_flag = 1'b0;
    checks++;
    if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL mthi_mtlo_both got hi=%h lo=%h want both 0badf00d", bus.hi, bus.lo);
    end
  endtask

  task automatic test_flag_clear_by_write();
    run_op(2'b11, 32'd9, 32'd0);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_00AB;
    @(posedge clk); #1;
    bus.wr_lo = 1'b0;
    exp_flag = 1'b0;
    checks++;
    if (bus.lo !== 32'h0000_00AB) begin
      errors++;
      $display("FAIL mtlo_after_div0 got=%h want=000000ab", bus.lo);
    end
`ifdef MULDIV_DIVZERO_FLAG_EN
    checks++;
    if (bus.div_by_zero !== exp_flag) begin
      errors++;
      $display("FAIL flag_clear_by_write got=%b want=%b", bus.div_by_zero, exp_flag);
    end
`endif
  endtask

  // Start/wr pulses mid-operation and start+write together in IDLE.
  task automatic test_isolation();
    int lat;
    bit seen;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_1234;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd2; bus.op_b = 32'd3;
    bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_0055;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_lo = 1'b0;
    bus.op = 2'b10; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'd0;
    checks++;
    if (bus.lo !== 32'h0000_1234 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_write got lo=%h busy=%b want lo=00001234 busy=1", bus.lo, bus.busy);
    end
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 4) begin
        bus.start = 1'b1; bus.wr_hi = 1'b1; bus.wr_data = 32'h0000_00AA;
      end else if (lat == 5) begin
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        checks++;
        if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_1234) begin
          errors++;
          $display("FAIL stale_hilo_busy got hi=%h lo=%h want 00001234", bus.hi, bus.lo);
        end
      end
      if (bus.done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || lat !== LAT || bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
      errors++;
      $display("FAIL isolation seen=%0d lat=%0d hi=%h lo=%h want lat=%0d hi=0 lo=6",
               seen, lat, bus.hi, bus.lo, LAT);
    end
    exp_flag = 1'b0;
    @(posedge clk); #1;
  endtask

  // A start held across the done cycle is accepted only once back in IDLE.
  task automatic test_back_to_back();
    int lat;
    bit seen;
    logic [63:0] exp;
    run_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    bus.start = 1'b1; bus.op = 2'b11; bus.op_a = 32'd100; bus.op_b = 32'd7;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || lat !== 1 + LAT) begin
      errors++;
      $display("FAIL held_start_latency seen=%0d got=%0d want=%0d", seen, lat, 1 + LAT);
    end
    // Still holding start during DONE: must not be taken there.
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL start_in_done_ignored got busy=%b state=%0d want busy=0 state=0",
               bus.busy, bus.dbg_state);
    end
    exp = model(2'b01, 32'd6, 32'd9);
    bus.op = 2'b01; bus.op_a = 32'd6; bus.op_b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_done got busy=%b want=1", bus.busy);
    end
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || lat !== LAT || {bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL back_to_back seen=%0d lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               seen, lat, bus.hi, bus.lo, LAT, exp[63:32], exp[31:0]);
    end
    exp_flag = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] corners[5];
    logic [31:0] a, b;
    logic [1:0] o;
    corners[0] = 32'd0; corners[1] = 32'd1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 5))
        0:       b = corners[$urandom_range(0, 4)];
        1:       b = 32'($urandom_range(0, 15));
        2:       b = 32'd0;
        default: b = $urandom;
      endcase
      run_op(o, a, b);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd2; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_flag = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op got busy=%b done=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) cyc++;
    end
    checks++;
    if (cyc !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset got %0d active cycles want 0", cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_divzero();
    test_mthi_mtlo();
    test_flag_clear_by_write();
    test_isolation();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file.
- Consumes the two register read operands and produces results into dedicated HI/LO registers, which later feed the writeback mux.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles using a start/busy/done handshake.
- Also supports direct HI/LO writes for MTHI and MTLO.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only in IDLE
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
op_a  input  DATA_WIDTH  readData1 (multiplicand/dividend)
op_b  input  DATA_WIDTH  readData2 (multiplier/divisor)
wr_hi  input  1  MTHI write strobe
wr_lo  input  1  MTLO write strobe
wr_data  input  DATA_WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO just updated
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE. Reset asserted mid-operation aborts immediately; no done pulse, HI/LO=0.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 latches op, operand magnitudes and result signs; go to RUN.
  - Signed ops take two's-complement magnitudes.
- RUN:
  - Runs exactly DATA_WIDTH cycles, one bit per cycle.
  - Multiply: shift-add producing a 2*DATA_WIDTH product.
  - Divide: restoring shift-subtract.
- FIX: one cycle applying sign correction.
  - Product negated if signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- DONE:
  - HI/LO written at the edge entering DONE.
  - done=1 for exactly that cycle, then IDLE.
- Latency: done high in the cycle after edge E(DATA_WIDTH+2), i.e. 34 cycles after start for 32-bit.
- busy:
  - High from the cycle after E0 through the FIX cycle.
  - Low in the DONE cycle; start is not accepted in DONE, it is accepted only back in IDLE.
- Results:
  - Multiply: HI=upper half, LO=lower half of the product.
  - Divide: LO=quotient, HI=remainder.
- Divide by zero:
  - Full latency still applies.
  - LO=all ones, HI=op_a unchanged.
  - Identical for DIV and DIVU.
- Overflow: DIV of most-negative by -1 gives LO=0x80000000, HI=0; no trap.
- Operand isolation: op_a, op_b and op may change after E0 without affecting the result.
- wr_hi/wr_lo:
  - Honoured only in IDLE; ignored while busy or in DONE.
  - Both set in the same cycle writes wr_data to both registers.
  - start and wr_* in the same IDLE cycle: start wins, write dropped.
- Stale outputs: HI/LO hold their previous values throughout an operation until DONE.

Optional Feature:
- Macro: MULDIV_DIVZERO_FLAG_EN.
- Enabled:
  - Adds output port div_by_zero (1 bit), reset 0.
  - Set at the DONE edge of any DIV/DIVU with op_b=0; cleared at the DONE edge of any other operation or by an MTHI/MTLO write.
  - HI/LO values are unchanged by the flag.
- Disabled: port absent; no other behaviour change.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 34 cycles after start; busy low during the done cycle.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
  - With MULDIV_DIVZERO_FLAG_EN: div_by_zero=1, then a following MULTU 2x3 clears it.
- Start MULTU 2x3, then pulse start and wr_hi (wr_data=0xAA) at cycle 5 -> both ignored; result HI=0, LO=6.
- Second run: reset at cycle 10 -> busy=0, HI=LO=0, no done pulse.
